// File: rtl/axis_adc_master_if.sv
// ---------------------------------------------------------------------------
// axis_adc_master_if
// AXI4-Stream bundle carried by the ADC streamer.
//   tdata  DATA_W    beat payload
//   tstrb  DATA_W/8  byte strobes
//   tkeep  DATA_W/8  byte keeps
//   tvalid 1         beat valid
//   tlast  1         last beat of packet
//   tready 1         sink ready
// Modports: master (drives the stream), slave (drives tready).
// ---------------------------------------------------------------------------
interface axis_adc_master_if #(
    parameter int DATA_W = 16
) ();
    logic [DATA_W-1:0]   tdata;
    logic [DATA_W/8-1:0] tstrb;
    logic [DATA_W/8-1:0] tkeep;
    logic                tvalid;
    logic                tlast;
    logic                tready;

    modport master (output tdata, tstrb, tkeep, tvalid, tlast, input tready);
    modport slave  (input tdata, tstrb, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_adc_master.sv
// ---------------------------------------------------------------------------
// axis_adc_master
// Captures ADC samples on a sampled strobe (adc_clk) and streams them out as
// zero-extended AXI4-Stream beats, framed into packets of PKT_LEN beats.
//
// Ports:
//   m_axis_aclk     system clock, rising edge
//   m_axis_aresetn  asynchronous active-low reset
//   adc_clk         ADC sample strobe (asynchronous, treated as data)
//   adc_data        ADC sample, changes on adc_clk rising edge
//   m_axis          AXIS master (tdata/tstrb/tkeep/tvalid/tlast/tready)
//   adc_overflow    sticky dropped-sample flag (only with AXIS_ADC_OVF_FLAG_EN)
//
// Optional feature macro: AXIS_ADC_OVF_FLAG_EN
// ---------------------------------------------------------------------------
module axis_adc_master #(
    parameter int ADC_W      = 14,
    parameter int DATA_W     = 16,
    parameter int PKT_LEN    = 64,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             m_axis_aclk,
    input  logic             m_axis_aresetn,
    input  logic             adc_clk,
    input  logic [ADC_W-1:0] adc_data,
    axis_adc_master_if.master m_axis
`ifdef AXIS_ADC_OVF_FLAG_EN
    ,
    output logic             adc_overflow
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(PKT_LEN);
    localparam logic [CW-1:0] LAST_BEAT = CW'(PKT_LEN - 1);

    // sync_q[0]/[1] form the synchronizer, sync_q[2] is the edge-detect flop
    logic [2:0]       sync_q, sync_d;
    logic [ADC_W-1:0] data_q, data_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    beat_q, beat_d;
    logic [ADC_W-1:0] mem [FIFO_DEPTH];

    logic capture, empty, full, push, pop;

    always_comb begin
        sync_d  = {sync_q[1:0], adc_clk};
        capture = sync_q[1] & ~sync_q[2];
        // adc_data is registered every cycle; at the write edge data_q holds
        // the value sampled one cycle after the strobe was first seen high,
        // so the sample has settled well clear of its own adc_clk edge.
        data_d  = adc_data;

        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop   = !empty && m_axis.tready;
        // A pop in the same cycle frees the slot, so push is legal even when full
        push  = capture && (!full || pop);

        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);

        beat_d = beat_q;
        if (pop) beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) begin
            sync_q   <= '0;
            data_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            beat_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            beat_q   <= beat_d;
        end
    end

    // Storage needs no reset: the empty flag masks stale contents
    always_ff @(posedge m_axis_aclk) begin
        if (push) mem[wr_ptr_q[AW-1:0]] <= data_q;
    end

`ifdef AXIS_ADC_OVF_FLAG_EN
    logic drop;
    logic ovf_q, ovf_d;

    always_comb begin
        drop  = capture && full && !pop;
        ovf_d = ovf_q | drop;
    end

    always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
        if (!m_axis_aresetn) ovf_q <= 1'b0;
        else                 ovf_q <= ovf_d;
    end

    assign adc_overflow = ovf_q;
`endif

    // Head entry is forced to zero when empty so tdata reads 0 while idle
    assign m_axis.tvalid = !empty;
    assign m_axis.tdata  = empty ? '0
                         : {{(DATA_W-ADC_W){1'b0}}, mem[rd_ptr_q[AW-1:0]]};
    assign m_axis.tlast  = !empty && (beat_q == LAST_BEAT);
    assign m_axis.tstrb  = '1;
    assign m_axis.tkeep  = '1;
endmodule

// File: tb/tb_axis_adc_master.sv
module tb_axis_adc_master;
    localparam int ADC_W   = 14;
    localparam int DATA_W  = 16;
    localparam int PKT_LEN = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             adc_clk = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
`ifdef AXIS_ADC_OVF_FLAG_EN
    logic             adc_overflow;
`endif

    always #20 clk = ~clk;

    axis_adc_master_if #(.DATA_W(DATA_W)) axis ();

    axis_adc_master #(
        .ADC_W(ADC_W), .DATA_W(DATA_W), .PKT_LEN(PKT_LEN), .FIFO_DEPTH(16)
    ) dut (
        .m_axis_aclk    (clk),
        .m_axis_aresetn (rst_n),
        .adc_clk        (adc_clk),
        .adc_data       (adc_data),
        .m_axis         (axis.master)
`ifdef AXIS_ADC_OVF_FLAG_EN
        ,
        .adc_overflow   (adc_overflow)
`endif
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] exp_q[$];
    int          acc_cnt = 0;
    bit          lfsr_en = 1'b0;
    logic [5:0]  lfsr = 6'b100000;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data;
    logic        prev_last;
    logic [15:0] e;
    logic [13:0] v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One ADC period: strobe high with new data for 50 ns, low for 50 ns
    task automatic sample(input logic [13:0] val, input bit keep);
        adc_clk  = 1'b1;
        adc_data = val;
        if (keep) exp_q.push_back({2'b00, val});
        #50 adc_clk = 1'b0;
        #50;
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk);
        #2 axis.tready = r;
    endtask

    task automatic drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Random backpressure source
    always @(posedge clk) begin
        if (lfsr_en) begin
            #1;
            axis.tready = lfsr[0];
            lfsr = {lfsr[4:0], ~(lfsr[5] ^ lfsr[4])};
        end
    end

    // Monitor: pops expected beats on each handshake, checks hold and framing
    always @(negedge clk) begin
        if (!rst_n) begin
            acc_cnt   = 0;
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_valid", axis.tvalid, 1);
                check("hold_data", axis.tdata, prev_data);
                check("hold_last", axis.tlast, prev_last);
            end
            if (axis.tvalid && axis.tready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got %0h expected none", axis.tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("tdata", axis.tdata, e);
                end
                check("tlast", axis.tlast, (acc_cnt % PKT_LEN) == PKT_LEN - 1);
                check("tstrb", axis.tstrb, 2'b11);
                check("tkeep", axis.tkeep, 2'b11);
                acc_cnt++;
            end
            prev_hold = axis.tvalid && !axis.tready;
            prev_data = axis.tdata;
            prev_last = axis.tlast;
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        axis.tready = 1'b1;
        #5;
        // Reset held with the ADC running: outputs stay idle
        for (int i = 0; i < 4; i++) begin
            sample(14'(i + 100), 1'b0);
            check("rst_tvalid", axis.tvalid, 0);
            check("rst_tlast", axis.tlast, 0);
            check("rst_tdata", axis.tdata, 0);
        end
        rst_n = 1'b1;

        // Steady stream, tready high
        v = '0;
        for (int i = 0; i < 140; i++) begin sample(v, 1'b1); v++; end
        drain();

        // Overflow: 16 fit, next 4 dropped
        set_ready(1'b0);
        for (int i = 0; i < 16; i++) begin sample(v, 1'b1); v++; end
        #150;
        check("ovf_full_valid", axis.tvalid, 1);
`ifdef AXIS_ADC_OVF_FLAG_EN
        check("ovf_flag_before", adc_overflow, 0);
`endif
        sample(v, 1'b0); v++;
        #150;
`ifdef AXIS_ADC_OVF_FLAG_EN
        check("ovf_flag_set", adc_overflow, 1);
`endif
        for (int i = 0; i < 3; i++) begin sample(v, 1'b0); v++; end
        #150;
        set_ready(1'b1);
        for (int i = 0; i < 10; i++) begin sample(v, 1'b1); v++; end
        drain();
`ifdef AXIS_ADC_OVF_FLAG_EN
        check("ovf_flag_sticky", adc_overflow, 1);
`endif

        // Random backpressure
        @(negedge clk) lfsr_en = 1'b1;
        for (int i = 0; i < 150; i++) begin sample(v, 1'b1); v++; end
        @(negedge clk) lfsr_en = 1'b0;
        set_ready(1'b1);
        drain();

        // Wrap-around of the ADC code
        v = 14'h3FFE;
        for (int i = 0; i < 4; i++) begin sample(v, 1'b1); v++; end
        drain();

        // Reset mid-packet
        for (int i = 0; i < 200 && !((acc_cnt % PKT_LEN) >= 10 && (acc_cnt % PKT_LEN) < 20); i++) begin
            sample(v, 1'b1); v++;
        end
        check("midpkt_reached", ((acc_cnt % PKT_LEN) >= 10 && (acc_cnt % PKT_LEN) < 20), 1);
        set_ready(1'b0);
        for (int i = 0; i < 3; i++) begin sample(v, 1'b1); v++; end
        #150;
        check("pre_rst_valid", axis.tvalid, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_tvalid", axis.tvalid, 0);
        check("midrst_tlast", axis.tlast, 0);
        check("midrst_tdata", axis.tdata, 0);
        exp_q.delete();
        #99 rst_n = 1'b1;
        #100;
        check("post_rst_empty", axis.tvalid, 0);
`ifdef AXIS_ADC_OVF_FLAG_EN
        check("post_rst_ovf", adc_overflow, 0);
`endif
        set_ready(1'b1);
        for (int i = 0; i < 70; i++) begin sample(v, 1'b1); v++; end
        drain();
        check("post_rst_beats", acc_cnt, 70);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
